// File: rtl/se_squeeze_feeder.sv
// se_squeeze_feeder: accumulates per-channel sums of the depthwise output
// over a full H*W map for each 16-channel group, then hands each finished,
// saturated group to the SE divider. The next group keeps accumulating while
// the divider works on the previous group.
module se_squeeze_feeder #(
    parameter int Data_Width = 14,
    parameter int FBITS      = 7,
    parameter int IN_Burst   = 16,
    parameter int BWIDTH     = 12,
    parameter int ACC_EXT    = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_load,
    input  logic [BWIDTH-1:0]              cfg_pixels,
    input  logic [5:0]                     cfg_groups,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_Burst*Data_Width-1:0] in_data,
    output logic [IN_Burst*Data_Width-1:0] sum_data,
    output logic [BWIDTH-1:0]              divisor,
    output logic                           start_div,
    input  logic                           div_busy,
    input  logic                           div_done,
    output logic [5:0]                     group_idx,
    output logic                           sat_flag,
    output logic                           frame_done
);

    localparam int ACC_W = Data_Width + ACC_EXT;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (Data_Width - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (Data_Width - 1)));

    // The fixed-point format needs at least one integer bit besides the sign.
    if (FBITS >= Data_Width - 1) begin : g_fbits_check
        $error("se_squeeze_feeder: FBITS must be below Data_Width-1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD, S_DRAIN} state_t;

    state_t                           r_state;
    logic [BWIDTH-1:0]                r_cfg_pixels;
    logic [5:0]                       r_cfg_groups;
    logic [BWIDTH-1:0]                r_pix_cnt;
    logic [5:0]                       r_grp_cnt;
    logic signed [ACC_W-1:0]          r_acc [IN_Burst];
    logic [IN_Burst*Data_Width-1:0]   r_sum_data;
    logic [5:0]                       r_group_idx;
    logic                             r_pending;
    logic                             r_launched;
    logic                             r_start_div;
    logic                             r_sat_flag;

    logic                             w_accept;
    logic                             w_last_pix;
    logic                             w_last_grp;
    logic signed [ACC_W-1:0]          w_sum [IN_Burst];
    logic [IN_Burst*Data_Width-1:0]   w_sat_sum;
    logic [IN_Burst*Data_Width-1:0]   w_sat_acc;
    logic                             w_ovf_sum;
    logic                             w_ovf_acc;

    function automatic logic [Data_Width-1:0] f_sat(input logic signed [ACC_W-1:0] v);
        if (v > ACC_MAX)      return {1'b0, {(Data_Width-1){1'b1}}};
        else if (v < ACC_MIN) return {1'b1, {(Data_Width-1){1'b0}}};
        else                  return v[Data_Width-1:0];
    endfunction

    function automatic logic f_ovf(input logic signed [ACC_W-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_last_pix = (r_pix_cnt == r_cfg_pixels - 1'b1);
    assign w_last_grp = (r_grp_cnt == r_cfg_groups - 6'd1);

    // Per-lane running sum including the current beat, plus saturated views
    // of both that sum and the bare accumulator (used for the HOLD transfer).
    always_comb begin
        w_sat_sum = '0;
        w_sat_acc = '0;
        w_ovf_sum = 1'b0;
        w_ovf_acc = 1'b0;
        for (int unsigned i = 0; i < IN_Burst; i++) begin
            w_sum[i] = r_acc[i] + ACC_W'($signed(in_data[i*Data_Width +: Data_Width]));
            w_sat_sum[i*Data_Width +: Data_Width] = f_sat(w_sum[i]);
            w_sat_acc[i*Data_Width +: Data_Width] = f_sat(r_acc[i]);
            w_ovf_sum = w_ovf_sum | f_ovf(w_sum[i]);
            w_ovf_acc = w_ovf_acc | f_ovf(r_acc[i]);
        end
    end

    // Control FSM, accumulators, holding register and divider handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cfg_pixels <= '0;
            r_cfg_groups <= '0;
            r_pix_cnt    <= '0;
            r_grp_cnt    <= '0;
            r_acc        <= '{default: '0};
            r_sum_data   <= '0;
            r_group_idx  <= '0;
            r_pending    <= 1'b0;
            r_launched   <= 1'b0;
            r_start_div  <= 1'b0;
            r_sat_flag   <= 1'b0;
        end else begin
            r_start_div <= 1'b0;
            // A load only happens with pending clear, and div_done only acts
            // with pending set, so the two never fight over r_pending.
            if (div_done && r_pending) begin
                r_pending  <= 1'b0;
                r_launched <= 1'b0;
            end else if (r_pending && !r_launched && !div_busy) begin
                r_start_div <= 1'b1;
                r_launched  <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_cfg_pixels <= cfg_pixels;
                        r_cfg_groups <= cfg_groups;
                        r_pix_cnt    <= '0;
                        r_grp_cnt    <= '0;
                        r_sat_flag   <= 1'b0;
                        r_acc        <= '{default: '0};
                        r_state      <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (w_last_pix && !r_pending) begin
                            r_sum_data  <= w_sat_sum;
                            r_sat_flag  <= r_sat_flag | w_ovf_sum;
                            r_pending   <= 1'b1;
                            r_group_idx <= r_grp_cnt;
                            r_acc       <= '{default: '0};
                            r_pix_cnt   <= '0;
                            r_grp_cnt   <= r_grp_cnt + 6'd1;
                            r_state     <= w_last_grp ? S_DRAIN : S_ACCUM;
                        end else begin
                            r_acc <= w_sum;
                            if (w_last_pix) r_state   <= S_HOLD;
                            else            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!r_pending) begin
                        r_sum_data  <= w_sat_acc;
                        r_sat_flag  <= r_sat_flag | w_ovf_acc;
                        r_pending   <= 1'b1;
                        r_group_idx <= r_grp_cnt;
                        r_acc       <= '{default: '0};
                        r_pix_cnt   <= '0;
                        r_grp_cnt   <= r_grp_cnt + 6'd1;
                        r_state     <= w_last_grp ? S_DRAIN : S_ACCUM;
                    end
                end
                S_DRAIN: begin
                    if (div_done && r_pending) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_ACCUM);
    assign sum_data   = r_sum_data;
    assign divisor    = r_cfg_pixels;
    assign start_div  = r_start_div;
    assign group_idx  = r_group_idx;
    assign sat_flag   = r_sat_flag;
    assign frame_done = !rst && div_done && r_pending && (r_state == S_DRAIN);

endmodule

// File: tb/tb_se_squeeze_feeder.sv
// Directed bench for se_squeeze_feeder: a lane-sum model pushes expected
// groups into a scoreboard, and a divider model pops and checks them on
// every start_div.
module tb_se_squeeze_feeder;

    localparam int DW = 14;
    localparam int NL = 16;
    localparam int BW = 12;
    localparam int VW = DW * NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic [BW-1:0] cfg_pixels;
    logic [5:0]    cfg_groups;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic [VW-1:0] sum_data;
    logic [BW-1:0] divisor;
    logic          start_div;
    logic          div_busy;
    logic          div_done;
    logic [5:0]    group_idx;
    logic          sat_flag;
    logic          frame_done;

    always #5 clk = ~clk;

    se_squeeze_feeder #(
        .Data_Width (DW),
        .FBITS      (7),
        .IN_Burst   (NL),
        .BWIDTH     (BW),
        .ACC_EXT    (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_pixels (cfg_pixels),
        .cfg_groups (cfg_groups),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sum_data   (sum_data),
        .divisor    (divisor),
        .start_div  (start_div),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .group_idx  (group_idx),
        .sat_flag   (sat_flag),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [VW-1:0] sum;
        logic [BW-1:0] div;
        logic [5:0]    gidx;
        logic          last;
    } exp_t;

    exp_t sb[$];

    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_done  = 0;
    int   n_fd    = 0;
    int   div_dly = 4;

    int   m_acc [NL];
    int   m_pix;
    int   m_grp;
    int   m_pixels;
    int   m_groups;
    logic m_sat;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++) d[i*DW +: DW] = DW'(v);
        return d;
    endfunction

    task automatic model_beat(input logic [VW-1:0] d);
        logic signed [DW-1:0] ln;
        exp_t e;
        for (int i = 0; i < NL; i++) begin
            ln = d[i*DW +: DW];
            m_acc[i] += int'(ln);
        end
        m_pix++;
        if (m_pix == m_pixels) begin
            e.sum = '0;
            for (int i = 0; i < NL; i++) begin
                if (m_acc[i] > 8191) begin
                    e.sum[i*DW +: DW] = 14'h1FFF;
                    m_sat = 1'b1;
                end else if (m_acc[i] < -8192) begin
                    e.sum[i*DW +: DW] = 14'h2000;
                    m_sat = 1'b1;
                end else begin
                    e.sum[i*DW +: DW] = DW'(m_acc[i]);
                end
                m_acc[i] = 0;
            end
            e.div  = BW'(m_pixels);
            e.gidx = 6'(m_grp);
            e.last = (m_grp == m_groups - 1);
            sb.push_back(e);
            m_pix = 0;
            m_grp++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_acc[i] = 0;
        m_pix = 0;
        m_grp = 0;
        m_sat = 1'b0;
    endtask

    task automatic start_frame(input int p, input int g);
        cfg_pixels = BW'(p);
        cfg_groups = 6'(g);
        cfg_load   = 1'b1;
        @(posedge clk);
        #1;
        cfg_load   = 1'b0;
        m_pixels   = p;
        m_groups   = g;
        model_clear();
    endtask

    task automatic send_beat(input logic [VW-1:0] d);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (in_ready !== 1'b1) check("beat_timeout", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(d);
    endtask

    task automatic wait_done(input int target);
        int w;
        w = 0;
        while (n_done < target && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (n_done < target) check("done_timeout", n_done, target);
    endtask

    // Divider model: checks each launched group against the scoreboard,
    // holds it busy for div_dly cycles, then pulses div_done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (start_div === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_start", start_div, 0);
                end else begin
                    div_busy = 1'b1;
                    e = sb.pop_front();
                    check("sum_data", sum_data, e.sum);
                    check("divisor", divisor, e.div);
                    check("group_idx", group_idx, e.gidx);
                    @(negedge clk);
                    check("start_pulse_width", start_div, 0);
                    repeat (div_dly - 1) @(negedge clk);
                    check("sum_hold", sum_data, e.sum);
                    div_done = 1'b1;
                    #1;
                    check("frame_done", frame_done, e.last);
                    if (frame_done === 1'b1) n_fd++;
                    @(negedge clk);
                    div_done = 1'b0;
                    div_busy = 1'b0;
                    n_done++;
                end
            end
        end
    end

    initial begin
        logic [VW-1:0] d;
        int base;
        int fd0;

        rst        = 1'b1;
        cfg_load   = 1'b0;
        cfg_pixels = '0;
        cfg_groups = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        div_busy   = 1'b0;
        div_done   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_start_div", start_div, 0);
        check("rst_sum_data", sum_data, 0);
        check("rst_divisor", divisor, 0);
        check("rst_group_idx", group_idx, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_frame_done", frame_done, 0);

        // 4 pixels of 1.0, one group; start_div two cycles after last beat.
        base = n_done;
        div_dly = 5;
        start_frame(4, 1);
        for (int b = 0; b < 4; b++) send_beat(fill(14'h0080));
        @(negedge clk);
        check("latency_cycle1", start_div, 0);
        @(negedge clk);
        check("latency_cycle2", start_div, 1);
        wait_done(base + 1);
        check("t1_sat_flag", sat_flag, m_sat);

        // Full 56x56 map, two groups; group 1 accumulates while busy.
        base = n_done;
        div_dly = 50;
        start_frame(3136, 2);
        for (int b = 0; b < 3136; b++) send_beat(fill(1));
        for (int b = 0; b < 10; b++) send_beat(fill(1));
        check("accum_while_busy", in_ready, 1);
        for (int b = 0; b < 3126; b++) send_beat(fill(1));
        wait_done(base + 2);

        // Slow divider forces HOLD after the second group's last beat.
        base = n_done;
        div_dly = 20;
        start_frame(2, 2);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NL; i++) d[i*DW +: DW] = DW'((b + 1) * 100 - i * 37);
            send_beat(d);
        end
        @(negedge clk);
        check("hold_in_ready", in_ready, 0);
        wait_done(base + 2);

        // Saturation in both directions, other lanes exact.
        base = n_done;
        div_dly = 4;
        start_frame(100, 1);
        d = '0;
        d[0*DW +: DW] = 14'h1F00;
        d[1*DW +: DW] = 14'h2100;
        for (int i = 2; i < NL; i++) d[i*DW +: DW] = DW'(i * 8 - 40);
        for (int b = 0; b < 100; b++) send_beat(d);
        wait_done(base + 1);
        check("sat_flag_set", sat_flag, m_sat);

        // Reset mid-group aborts the frame; the next frame sees only new beats.
        base = n_done;
        start_frame(8, 1);
        for (int b = 0; b < 5; b++) send_beat(fill(14'h0100));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_sum_data", sum_data, 0);
        check("midrst_divisor", divisor, 0);
        repeat (20) @(negedge clk);
        start_frame(3, 1);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NL; i++) d[i*DW +: DW] = DW'(5 * (i + 1));
            send_beat(d);
        end
        wait_done(base + 1);

        // One pixel per group, 36 groups back to back.
        base = n_done;
        fd0 = n_fd;
        div_dly = 3;
        start_frame(1, 36);
        for (int g = 0; g < 36; g++) begin
            for (int i = 0; i < NL; i++)
                d[i*DW +: DW] = DW'((g % 2 == 1) ? -(g * 8 + i) : (g * 8 + i));
            send_beat(d);
        end
        wait_done(base + 36);
        check("frame_done_count", n_fd - fd0, 1);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/se_squeeze_feeder.md
Name: se_squeeze_feeder

Overview:
- Producer side of the SE block's squeeze (average) input. Consumes the depthwise output stream, 16 channels per beat, one spatial pixel per beat.
- Accumulates per-channel sums over the full H*W map for each 16-channel group.
- Presents each finished group as sum_data and divisor, with a one-cycle start_div pulse, to the SE divider.
- Double-buffered: the next group accumulates while the previous group is being divided.

Parameters:
- Data_Width, 14, signed fixed-point lane width (same Q format as SE block, FBITS fractional).
- FBITS, 7, fractional bits; no rescaling is applied, carried for documentation and assertions.
- IN_Burst, 16, channel lanes per beat.
- BWIDTH, 12, divisor width (max map size 56*56 = 3136).
- ACC_EXT, 12, accumulator guard bits; accumulator width = Data_Width+ACC_EXT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_load  in  1  one-cycle pulse; latches cfg_pixels and cfg_groups and starts a frame.
- cfg_pixels  in  BWIDTH  H*W pixels per map, legal range 1..3136.
- cfg_groups  in  6  16-channel groups per frame, legal range 1..36.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  feeder accepts a beat this cycle.
- in_data  in  IN_Burst*Data_Width  signed lanes; lane i at [i*Data_Width +: Data_Width].
- sum_data  out  IN_Burst*Data_Width  saturated group sums, same packing as in_data.
- divisor  out  BWIDTH  latched cfg_pixels.
- start_div  out  1  one-cycle division start pulse.
- div_busy  in  1  divider busy.
- div_done  in  1  divider finished current group.
- group_idx  out  6  index of the group currently held on sum_data.
- sat_flag  out  1  sticky: some lane saturated in this frame.
- frame_done  out  1  one-cycle pulse on div_done of the last group.

Behaviour:
- Reset: all accumulators, counters, pending and launched cleared; FSM to IDLE. Outputs: in_ready=0, start_div=0, sum_data=0, divisor=0, group_idx=0, sat_flag=0, frame_done=0.
- Reset mid-frame aborts the frame; no start_div is issued afterwards.
- FSM states:
  - IDLE: in_ready=0. cfg_load -> ACCUM. At cfg_load: latch config, clear pix_cnt, grp_cnt and sat_flag.
  - ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready. Each lane acc[i] += sign-extended in_data lane i; pix_cnt increments.
  - Last pixel of a group (pix_cnt==cfg_pixels-1), with the holding register free (!pending):
    - in the same cycle, load sum_data with the saturated value of (acc[i] + this beat), set pending, group_idx=grp_cnt;
    - clear acc to 0 and pix_cnt to 0, increment grp_cnt;
    - if this was the last group -> DRAIN, else stay in ACCUM.
  - Last pixel with pending=1: the beat is still accepted and summed, then -> HOLD.
  - HOLD: in_ready=0. When pending clears, transfer acc to the holding register the next cycle, with the same updates as above -> ACCUM or DRAIN.
  - DRAIN: in_ready=0. When pending clears -> IDLE.
- Launch rule: start_div=1 for exactly one cycle when pending&!launched&!div_busy; this sets launched.
  - Earliest launch is the cycle after pending sets.
  - sum_data, divisor and group_idx stay stable from load until div_done.
- div_done with pending: clears pending and launched.
  - If this was the last group (DRAIN), frame_done pulses in the same cycle.
  - A div_done with pending=0 is ignored.
- Saturation: a value above 2^(Data_Width-1)-1 is clamped to 0x1FFF; below -2^(Data_Width-1) it is clamped to 0x2000. Either case sets sat_flag.
  - Accumulators wrap silently only beyond Data_Width+ACC_EXT bits, which cannot occur for legal cfg_pixels.
- cfg_load outside IDLE is ignored.
- cfg_pixels=1: every beat completes a group.
- Latency: last beat accepted -> start_div is 2 cycles minimum, if div_busy=0.

Test Plan:
- cfg_pixels=4, cfg_groups=1, lanes all 0x0080 (1.0) over 4 beats -> start_div 2 cycles after the last beat; each sum_data lane=0x0200; divisor=4; frame_done on div_done.
- cfg_pixels=3136, cfg_groups=2, all lanes 0x0001 -> group 0 lanes=0x0C40, start_div once; group 1 accumulates during div_busy; second start_div only after the first div_done.
- Two groups with cfg_pixels=2; hold div_done off for 20 cycles -> in_ready drops after the 4th beat (HOLD); sum_data is unchanged until div_done; the second group launches afterwards with the correct sums.
- cfg_pixels=100, lane0=0x1F00 and lane1=0x2100 every beat -> lane0=0x1FFF, lane1=0x2000, sat_flag=1, other lanes exact.
- rst asserted mid-group with 5 beats accepted, then cfg_load with a new config -> no stale start_div; the first sum reflects only post-reset beats.
- cfg_pixels=1, cfg_groups=36, back-to-back beats with div_done 3 cycles after each start_div -> 36 start_div pulses, group_idx 0..35 in order, one frame_done.
